// File: rtl/popcount_arbiter.sv
// Round-robin arbiter feeding a popcount unit, plus a saturating running total
// of all delivered counts. One operand is in flight at a time:
// IDLE (grant) -> COUNT (popcount) -> RESP (hold result until accepted).
//
// Handshakes: req_ready is a one-cycle accept strobe. The operand on a lane is
// taken on the rising edge where req_valid and req_ready are both high for that
// lane. A result is transferred on the rising edge where rsp_valid and rsp_ready
// are both high. While rsp_valid is high, rsp_id and rsp_count do not change.
module popcount_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 10,
  parameter int ACCW  = 16,
  localparam int CW   = $clog2(NBITS + 1),
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*NBITS-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [CW-1:0]         rsp_count,
  input  logic                  acc_clear,
  output logic [ACCW-1:0]       acc_total,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Sum width wide enough that the carry out of the accumulator is visible.
  localparam int SW = ((ACCW > CW) ? ACCW : CW) + 1;

  state_t            state;
  state_t            state_next;
  logic [IDW-1:0]    last_grant;
  logic [NBITS-1:0]  op_q;
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [NBITS-1:0]  grant_data;
  logic              grant_en;
  logic [CW-1:0]     count_next;
  logic              handshake;
  logic [SW-1:0]     acc_sum;

  assign handshake = rsp_valid && rsp_ready;
  assign fsm_state = state;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic [IDW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Select the operand of the winning requester.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) grant_data = req_data[i*NBITS +: NBITS];
    end
  end

  // Population count of the latched operand, full range 0..NBITS.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NBITS; i++) begin
      count_next = count_next + CW'(op_q[i]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = COUNT;
      COUNT:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; req_ready is held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    grant_en  = 1'b0;
    if (state == IDLE && !rst && grant_found) begin
      req_ready[grant_idx] = 1'b1;
      grant_en             = 1'b1;
    end
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Latch operand and id on grant; register the popcount in COUNT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDW'(NREQ - 1);
      op_q       <= '0;
      rsp_id     <= '0;
      rsp_count  <= '0;
    end else begin
      if (grant_en) begin
        last_grant <= grant_idx;
        op_q       <= grant_data;
        rsp_id     <= grant_idx;
      end
      if (state == COUNT) rsp_count <= count_next;
    end
  end

  assign acc_sum = SW'(acc_total) + SW'(rsp_count);

  // Running total: clear wins over a coincident handshake; adds saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_total <= '0;
    end else if (acc_clear) begin
      acc_total <= '0;
    end else if (handshake) begin
      if (|acc_sum[SW-1:ACCW]) acc_total <= {ACCW{1'b1}};
      else                     acc_total <= acc_sum[ACCW-1:0];
    end
  end

endmodule
